// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - register file debug dumper: walks FIRST_REG..LAST_REG onto a valid/ready stream
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 dump request, honoured only when idle
//   busy, done            busy while a dump is in flight; done pulses once after the final handshake
//   rf_raddr, rf_rdata    combinational read port of the register file
//   out_valid/out_ready   output stream handshake
//   out_data/out_addr     captured word and its register address
//   out_last              final beat of the dump
//
// Optional feature: define REGDUMP_CHECKSUM_EN to append an XOR checksum beat
// (out_addr=0, out_last=1) after the LAST_REG word.

module regfile_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_addr,
    output logic              out_last
);

    generate
        if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
            $error("regfile_dump: need 0 <= FIRST_REG <= LAST_REG <= 31");
        end
    endgenerate

    localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A  = 5'(LAST_REG);

    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

    state_t              state_q, state_d;
    logic [4:0]          raddr_q, raddr_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [4:0]          addr_q, addr_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
    // Set once the LAST_REG word has been accepted: the next READ emits the checksum.
    logic                pend_q, pend_d;
`endif

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        last_d  = last_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d  = csum_q;
        pend_d  = pend_q;
`endif
        case (state_q)
            IDLE: begin
                raddr_d = FIRST_A;
                if (start) begin
                    state_d = READ;
                    busy_d  = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d  = '0;
                    pend_d  = 1'b0;
`endif
                end
            end
            READ: begin
                valid_d = 1'b1;
                state_d = SEND;
`ifdef REGDUMP_CHECKSUM_EN
                if (pend_q) begin
                    data_d = csum_q;
                    addr_d = 5'd0;
                    last_d = 1'b1;
                end else begin
                    data_d = rf_rdata;
                    addr_d = raddr_q;
                    last_d = 1'b0;
                    csum_d = csum_q ^ rf_rdata;
                end
`else
                data_d = rf_rdata;
                addr_d = raddr_q;
                last_d = (raddr_q == LAST_A);
`endif
            end
            SEND: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                        raddr_d = FIRST_A;
                    end else begin
                        state_d = READ;
`ifdef REGDUMP_CHECKSUM_EN
                        // Hold the address at LAST_REG rather than stepping past it.
                        if (raddr_q == LAST_A) begin
                            pend_d = 1'b1;
                        end else begin
                            raddr_d = raddr_q + 5'd1;
                        end
`else
                        raddr_d = raddr_q + 5'd1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            raddr_q <= FIRST_A;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= 5'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= '0;
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= csum_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign rf_raddr  = raddr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - scoreboard bench for regfile_dump (full range and a 4..6 instance)

module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, start2, out_ready;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  rf_raddr, out_addr;
    logic [31:0] rf_rdata, out_data;
    logic        busy2, done2, out_valid2, out_last2;
    logic [4:0]  rf_raddr2, out_addr2;
    logic [31:0] rf_rdata2, out_data2;

    logic [31:0] regs [32];
    assign rf_rdata  = regs[rf_raddr];
    assign rf_rdata2 = regs[rf_raddr2];

    regfile_dump dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
    );

    regfile_dump #(.FIRST_REG(4), .LAST_REG(6), .DATA_W(32)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2), .out_valid(out_valid2),
        .out_ready(1'b1), .out_data(out_data2), .out_addr(out_addr2), .out_last(out_last2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int beats    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard side: every accepted beat is matched against the next expected one.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid && out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                check_eq("extra_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("beat_data", out_data, e.data);
                check_eq("beat_addr", out_addr, e.addr);
                check_eq("beat_last", out_last, e.last);
            end
        end
    end

    task automatic push_dump(input int first, input int last);
        logic [31:0] x;
        x = '0;
        for (int i = first; i <= last; i++) begin
            exp_q.push_back('{data: regs[i], addr: 5'(i), last: (i == last) && !CS});
            x ^= regs[i];
        end
        if (CS) exp_q.push_back('{data: x, addr: 5'd0, last: 1'b1});
    endtask

    task automatic run_dump(input string tag, input int stall_at, input int restart_at,
                            input int rst_at, input int exp_cyc, input int exp_beats);
        int t0, b0, i, done_at, extra;
        bit stalled, restarted;
        logic [31:0] orig;
        b0 = beats; done_at = -1; stalled = 0; restarted = 0; i = 0; extra = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        check_eq({tag, "_busy_on_accept"}, busy, 1'b1);
        while (done_at < 0 && i < 400) begin
            if (done) begin
                done_at = cyc - t0;
                check_eq({tag, "_busy_at_done"}, busy, 1'b0);
            end else if (rst_at >= 0 && out_valid && out_addr == 5'(rst_at)) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_eq({tag, "_rst_valid"}, out_valid, 1'b0);
                check_eq({tag, "_rst_busy"}, busy, 1'b0);
                check_eq({tag, "_rst_done"}, done, 1'b0);
                check_eq({tag, "_rst_raddr"}, rf_raddr, 5'd0);
                while (exp_q.size() > 0) void'(exp_q.pop_front());
                repeat (6) begin
                    @(posedge clk); #1;
                    if (done || busy) extra++;
                end
                check_eq({tag, "_rst_quiet"}, extra, 0);
                check_eq({tag, "_beats"}, beats - b0, exp_beats);
                return;
            end else if (stall_at >= 0 && !stalled && out_valid && out_addr == 5'(stall_at)) begin
                stalled = 1;
                out_ready = 1'b0;
                orig = regs[stall_at];
                regs[stall_at] = ~orig;
                repeat (5) begin
                    @(posedge clk); #1;
                    check_eq({tag, "_stall_valid"}, out_valid, 1'b1);
                    check_eq({tag, "_stall_data"}, out_data, orig);
                    check_eq({tag, "_stall_addr"}, out_addr, 5'(stall_at));
                end
                regs[stall_at] = orig;
                out_ready = 1'b1;
            end else if (restart_at >= 0 && !restarted && out_valid && out_addr == 5'(restart_at)) begin
                restarted = 1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                i++;
                continue;
            end
            if (done_at < 0) begin
                @(posedge clk); #1;
                i++;
            end
        end
        check_eq({tag, "_done_cycles"}, 64'(done_at), 64'(exp_cyc));
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy || out_valid) extra++;
        end
        check_eq({tag, "_quiet_after_done"}, extra, 0);
        check_eq({tag, "_beats"}, beats - b0, exp_beats);
        check_eq({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int k, t0, d2;
        logic [31:0] x2;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_last", out_last, 1'b0);
        check_eq("rst_data", out_data, 32'h0);
        check_eq("rst_addr", out_addr, 5'd0);
        check_eq("rst_raddr", rf_raddr, 5'd0);
        check_eq("rst_raddr2", rf_raddr2, 5'd4);
        rst = 1'b0;
        @(posedge clk); #1;

        push_dump(0, 31);
        run_dump("full", -1, -1, -1, CS ? 66 : 64, CS ? 33 : 32);
        push_dump(0, 31);
        run_dump("stall", 3, -1, -1, CS ? 71 : 69, CS ? 33 : 32);
        push_dump(0, 31);
        run_dump("restart", -1, 10, -1, CS ? 66 : 64, CS ? 33 : 32);
        push_dump(0, 31);
        run_dump("midrst", -1, -1, 12, 0, 12);

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        push_dump(0, 31);
        run_dump("random", -1, -1, -1, CS ? 66 : 64, CS ? 33 : 32);

        // Narrow instance: addresses 4..6 only, ready tied high.
        k = 0; d2 = -1; x2 = '0;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 30 && d2 < 0; i++) begin
            if (done2) d2 = cyc - t0;
            if (out_valid2) begin
                if (k < 3) begin
                    check_eq("n_addr", out_addr2, 5'(4 + k));
                    check_eq("n_data", out_data2, regs[4 + k]);
                    check_eq("n_last", out_last2, (k == 2) && !CS);
                    x2 ^= regs[4 + k];
                end else begin
                    check_eq("n_csum_data", out_data2, x2);
                    check_eq("n_csum_addr", out_addr2, 5'd0);
                    check_eq("n_csum_last", out_last2, 1'b1);
                end
                k++;
            end
            @(posedge clk); #1;
        end
        check_eq("n_beats", k, CS ? 4 : 3);
        check_eq("n_done_cycles", 64'(d2), CS ? 64'd8 : 64'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
